// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives ps2_clk/ps2_data only through active-high pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int REQ_CYCLES     = 40,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2((INHIBIT_CYCLES > REQ_CYCLES ? INHIBIT_CYCLES : REQ_CYCLES) + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_ACK, S_ACK_REL
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          ack_err_q, ack_err_d, tmo_err_q, tmo_err_d;
  logic          clk_s, data_s, tmo_hit;

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_filt_d  = clk_filt_q;
    filt_cnt_d  = '0;
    if (clk_s != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_s;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    ack_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_start) begin
          shift_d     = tx_data;
          parity_d    = ~^tx_data;
          bit_cnt_d   = '0;
          phase_cnt_d = '0;
          state_d     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (phase_cnt_q == PW'(INHIBIT_CYCLES - 1)) begin
          phase_cnt_d = '0;
          data_oe_d   = 1'b1;
          state_d     = S_REQ;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (phase_cnt_q == PW'(REQ_CYCLES - 1)) begin
          tmo_cnt_d = '0;
          state_d   = S_SEND;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      // Timeout takes priority over any edge handled in the same cycle.
      S_SEND: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_hit) begin
          tmo_err_d = 1'b1;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end else if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8)       data_oe_d = ~shift_q[bit_cnt_q[2:0]];
          else if (bit_cnt_q == 4'd8) data_oe_d = ~parity_q;
          else begin
            data_oe_d = 1'b0;
            state_d   = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (fall_q) begin
          if (data_s) begin
            ack_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_ACK_REL;
          end
        end
      end
      S_ACK_REL: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (clk_filt_q && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      phase_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
      phase_cnt_q <= phase_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = tmo_err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
// The device model clocks the lines, decodes the frame and answers with (or without) ACK.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 40, REQ = 4, TMO = 20000, FLT = 8;
  localparam int K_DONE = 0, K_ACK = 1, K_TMO = 2;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_oe, data_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  always #5 pclk = ~pclk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)
  ) dut (
    .pclk(pclk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  typedef struct packed { logic [1:0] kind; logic [7:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  rx_q[$];
  int          checks = 0, errors = 0;
  longint      cyc = 0, rel_cyc = 0;
  bit          busy_chk_next = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a completion pulse appears.
  always @(negedge pclk) begin : monitor
    exp_t e;
    if (busy_chk_next) begin
      check("busy_low_after_done", busy, 0);
      busy_chk_next = 1'b0;
    end
    if (!rst && (done || ack_err || timeout_err)) begin
      check("pulse_onehot", 64'(done) + 64'(ack_err) + 64'(timeout_err), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("outcome_kind", done ? K_DONE : (ack_err ? K_ACK : K_TMO), 64'(e.kind));
        check("lines_released", {clk_oe, data_oe}, 0);
        if (done) busy_chk_next = 1'b1;
        if (done || ack_err) begin
          if (rx_q.size() == 0) check("rx_frame_present", 0, 1);
          else                  check("rx_byte", rx_q.pop_front(), e.data);
        end else begin
          check("timeout_latency", 64'(cyc - rel_cyc), TMO);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int kind);
    int t = 0;
    while (busy && t < 50000) begin @(negedge pclk); t++; end
    @(negedge pclk);
    tx_data  = d;
    tx_start = 1'b1;
    if (kind >= 0) exp_q.push_back('{kind: 2'(kind), data: d});
    @(negedge pclk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  // Device side: measure the request, then clock npulse bits (10 = full frame + ACK slot).
  task automatic dev_xfer(input int half, input int npulse, input bit give_ack, input bit glitch);
    int t = 0, hi_cnt = 0, first_data = 0;
    logic [9:0] s = '0;
    logic [7:0] b;
    while (!clk_oe && t < 1000) begin @(negedge pclk); t++; end
    if (!clk_oe) begin check("request_seen", 0, 1); return; end
    while (clk_oe && hi_cnt < 10000) begin
      hi_cnt++;
      if (data_oe && first_data == 0) first_data = hi_cnt;
      @(negedge pclk);
    end
    rel_cyc = cyc;
    check("clk_oe_high_cycles", hi_cnt, INH + REQ);
    check("data_oe_rise_cycle", first_data, INH + 1);
    check("start_bit_low", ps2_data_line, 0);
    repeat (half) @(negedge pclk);
    for (int i = 0; i < npulse; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(negedge pclk);
      dev_clk_low = 1'b0;
      s[i] = ps2_data_line;
      if (glitch && i == 2) begin
        repeat (half / 2) @(negedge pclk);
        glitch_low = 1'b1;
        @(negedge pclk);
        glitch_low = 1'b0;
        repeat (half - half / 2 - 1) @(negedge pclk);
      end else begin
        repeat (half) @(negedge pclk);
      end
    end
    if (npulse == 10) begin
      b = s[7:0];
      check("parity_bit_odd", s[8], ~^b);
      check("stop_bit", s[9], 1);
      rx_q.push_back(b);
      if (give_ack) dev_data_low = 1'b1;
      repeat (half / 2) @(negedge pclk);
      dev_clk_low = 1'b1;
      repeat (half) @(negedge pclk);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (half) @(negedge pclk);
    end
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < limit) begin @(negedge pclk); t++; end
    check("drain_in_time", (exp_q.size() == 0 && !busy), 1);
    repeat (20) @(negedge pclk);
  endtask

  task automatic stray_start(input int delay);
    repeat (delay) @(negedge pclk);
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    @(negedge pclk);
    tx_start = 1'b0;
  endtask

  initial begin : watchdog
    repeat (150000) @(posedge pclk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] r;
    repeat (5) @(negedge pclk);
    check("reset_outputs", {clk_oe, data_oe, busy, done, ack_err, timeout_err}, 0);
    rst = 1'b0;
    repeat (20) @(negedge pclk);

    fork send(8'hF4, K_DONE); dev_xfer(400, 10, 1'b1, 1'b0); join
    drain(2000);
    fork send(8'hFF, K_DONE); dev_xfer(400, 10, 1'b1, 1'b0); join
    drain(2000);

    r = 8'($urandom);
    fork send(r, K_ACK); dev_xfer(200, 10, 1'b0, 1'b0); join
    drain(2000);

    fork send(8'h3C, K_TMO); dev_xfer(400, 5, 1'b0, 1'b0); join
    drain(25000);

    fork send(8'hC3, -1); dev_xfer(400, 4, 1'b0, 1'b0); join
    rst = 1'b1;
    @(negedge pclk);
    check("rst_mid_lines", {clk_oe, data_oe}, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge pclk);

    fork send(8'h55, K_DONE); dev_xfer(400, 10, 1'b1, 1'b1); stray_start(2000); join
    drain(2000);
    check("no_queued_start", busy, 0);

    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom);
      fork send(r, K_DONE); dev_xfer(100, 10, 1'b1, k == 1); join
      drain(2000);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    check("rx_queue_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
